// File: rtl/dense_relu_argmax_collector.sv
// Layer result collector: optional ReLU, result buffer, running argmax.
// One result per cycle; registered read port with one cycle of latency.
module dense_relu_argmax_collector #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   numNeurons,
  input  logic          reluEnable,
  input  logic [31:0]   dataIn,
  input  logic          dataValid,
  input  logic [AW-1:0] rdAddr,
  output logic [31:0]   rdData,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [AW-1:0] maxIndex,
  output logic [31:0]   maxValue
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

  state_t      state;
  state_t      nxt;
  logic [AW:0] lim;
  logic [AW:0] nlim;
  logic        relu;
  logic        accept;
  logic        last;
  logic [AW:0] cnt_inc;
  logic [31:0] v;
  logic [31:0] mem [DEPTH];

  assign nlim = (numNeurons > 32'(DEPTH))
              ? DMAX : numNeurons[AW:0];
  assign accept  = (state == COLLECT)
                 && dataValid && !start;
  assign v       = (relu && dataIn[31])
                 ? 32'h0 : dataIn;
  assign cnt_inc = count + 1'b1;
  assign last    = (cnt_inc == lim);
  assign busy    = (state == COLLECT);
  assign done    = (state == DONE);

  // Next-state: start wins; the final accept closes the layer.
  always_comb begin
    nxt = state;
    unique case (1'b1)
      start: begin
        if (nlim == '0) nxt = DONE;
        else            nxt = COLLECT;
      end
      (accept && last): nxt = DONE;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Layer context, counter, argmax and read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      maxIndex <= '0;
      maxValue <= '0;
      rdData   <= '0;
      lim      <= '0;
      relu     <= 1'b0;
    end else begin
      rdData <= mem[rdAddr];
      if (start) begin
        count    <= '0;
        maxIndex <= '0;
        maxValue <= '0;
        lim      <= nlim;
        relu     <= reluEnable;
      end else if (accept) begin
        count <= cnt_inc;
        if (count == '0 ||
            $signed(v) > $signed(maxValue)) begin
          maxValue <= v;
          maxIndex <= count[AW-1:0];
        end
      end
    end
  end

  // Result buffer; unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[count[AW-1:0]] <= v;
  end

endmodule

// File: doc/dense_relu_argmax_collector.md
# dense_relu_argmax_collector

Downstream consumer of the dense accelerator. It captures the stream of per-neuron Q8.24 results for one layer and applies an optional ReLU to each. Results are stored in an on-chip buffer that software or the next layer's operand sequencer can read back. While collecting, the block tracks the argmax, which gives the final garbage-class decision.

## Interface
Parameters:
- DEPTH, 64: maximum neurons per layer (buffer entries).
- AW, 6: address width, equal to clog2(DEPTH).

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- reset, in, 1: synchronous, active-low reset.
- start, in, 1: one-cycle pulse that begins a new layer collection.
- numNeurons, in, 32: number of results expected; sampled on start.
- reluEnable, in, 1: when 1, negative results are stored as 0; sampled on start.
- dataIn, in, 32: dense result in signed Q8.24 (bits 31:24 integer, 23:0 fraction, two's complement).
- dataValid, in, 1: dataIn holds a new result this cycle.
- rdAddr, in, AW: buffer read address.
- rdData, out, 32: buffer contents at rdAddr, registered.
- busy, out, 1: high while in COLLECT.
- done, out, 1: high in DONE; stays high until the next start or reset.
- count, out, AW+1: number of results accepted so far in this layer.
- maxIndex, out, AW: index of the largest stored (post-ReLU) value.
- maxValue, out, 32: largest stored value.

## Operation
- **States:** IDLE, COLLECT, DONE.
- **start handling (any state):**
  - clears count, maxIndex and maxValue.
  - latches N = min(numNeurons, DEPTH) and reluEnable.
  - goes to COLLECT if N > 0, otherwise goes directly to DONE.
- **In COLLECT, each cycle with dataValid=1 (accept):**
  - v = (reluEnable && dataIn[31]) ? 0 : dataIn.
  - buffer[count] <= v, then count <= count + 1.
- **Argmax:**
  - The first accepted value of a layer loads maxValue and maxIndex unconditionally.
  - Each later value replaces them only if it is strictly greater in a signed compare. Ties therefore keep the lowest index.
- **End of layer:** the accept that brings count to N moves COLLECT to DONE on the same edge.
- **Ignored inputs:** dataValid is ignored in IDLE and DONE. Extra results beyond N are dropped, and count, max and buffer are unchanged.
- **start and dataValid in the same cycle:** start wins and the data is dropped.
- **Restart:** start during COLLECT abandons the current layer and restarts. Buffer entries are not cleared.
- **Read port:** works in every state. Entries at or above count hold stale data, and the bench must not check them.
- **Arithmetic:** no rounding or saturation. Values pass through unchanged apart from the ReLU.

## Timing
- **Reset values:** while reset=0 at a clock edge, the state goes to IDLE and busy, done, count, maxIndex, maxValue and rdData all go to 0.
- **Reset mid-COLLECT:** aborts the layer with the same values as above. Buffer contents are undefined afterwards.
- **start:** sampled at edge k. busy (or done, when N=0) is high after edge k.
- **Accept:** a sample at edge k is visible in count, maxIndex and maxValue after edge k.
- **Last sample:** after the edge that accepts it, busy=0 and done=1 in the same cycle that count reaches N.
- **Throughput:** one result per cycle, back-to-back, with no stall output. The upstream stage may assert dataValid on any cycle.
- **Read latency:** rdData reflects the buffer at the rdAddr sampled on the previous edge, so latency is 1 cycle.
- **Read during write:** a read of the address being written in the same cycle returns the old contents.

## Test plan
- **Basic layer:** reset, then start with N=4 and relu=0; feed 0x2C000000 (44), 0x3E000000 (62), 0x50000000 (80), 0xE6000000 (-26) on consecutive cycles. Required: done=1 after the 4th edge, count=4, maxIndex=2, maxValue=0x50000000, and reads of addresses 0..3 return the inputs 1 cycle later.
- **ReLU:** start with N=3 and relu=1; feed 0xE6000000, 0xFF800000, 0x00400000. Required: buffer = 0, 0, 0x00400000; maxIndex=2.
- **Ties and all-negative:** start with N=3, relu=0; feed 0xFF000000 three times. Required: maxIndex=0 and maxValue=0xFF000000.
- **Boundaries:**
  - Start with N=0: done=1 one edge later, count=0, maxIndex=0, maxValue=0.
  - Start with N=100 (DEPTH=64): exactly 64 results are accepted, then done=1.
  - dataValid held for extra cycles after done: count stays at N.
- **Gaps and restart:** feed N=3 results with idle gaps between them; expect the same results as back-to-back. Then pulse start together with dataValid during COLLECT: that data is dropped and count=0.
- **Reset mid-COLLECT:** reset=0 after 2 of 4 results. Required: busy=0, done=0, count=0, maxValue=0; a new start works normally.
